// File: rtl/fanout_pkg.sv
// Shared defaults and branch-mask type for the fanout fork.
package fanout_pkg;

  localparam int FANOUT_NUM_OUT_DEF    = 6;
  localparam int FANOUT_DATA_WIDTH_DEF = 17;
  localparam int FANOUT_MASK_MAX       = 16;

  typedef logic [FANOUT_MASK_MAX-1:0] fanout_mask_t;

  function automatic fanout_mask_t active_mask(input fanout_mask_t en, input fanout_mask_t sel);
    return en & sel;
  endfunction

endpackage

// File: rtl/fanout_skid_buf.sv
// Two-entry ready/valid stage; in_ready is a registered ~full so no ready path crosses it.
module fanout_skid_buf
  import fanout_pkg::*;
#(
  parameter int DATA_WIDTH = FANOUT_DATA_WIDTH_DEF
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);

  logic [DATA_WIDTH-1:0] mem [2];
  logic [1:0] count, count_nxt;
  logic       wr_ptr, rd_ptr, rdy_q;
  logic       enq, deq;

  assign in_ready  = rdy_q & ~RESET;
  assign out_valid = (count != 2'd0) & ~RESET;
  assign out_data  = mem[rd_ptr];
  assign enq       = in_valid & in_ready;
  assign deq       = out_valid & out_ready;

  always_comb begin
    count_nxt = count;
    if (enq && !deq)      count_nxt = count + 2'd1;
    else if (!enq && deq) count_nxt = count - 2'd1;
  end

  // rdy_q resets high so the stage can accept in the first cycle out of reset
  always_ff @(posedge CLK) begin
    if (RESET) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      rdy_q  <= 1'b1;
    end else begin
      count <= count_nxt;
      rdy_q <= (count_nxt != 2'd2);
      if (enq) wr_ptr <= ~wr_ptr;
      if (deq) rd_ptr <= ~rd_ptr;
    end
  end

  always_ff @(posedge CLK) begin
    if (enq) mem[wr_ptr] <= in_data;
  end

endmodule

// File: rtl/fanout_fork.sv
// Eager fork: broadcasts one ready/valid stream to NUM_OUT branches, each taking a token once.
// Optional input skid buffer when FANOUT_SKID_EN is defined.
module fanout_fork
  import fanout_pkg::*;
#(
  parameter int NUM_OUT    = FANOUT_NUM_OUT_DEF,
  parameter int DATA_WIDTH = FANOUT_DATA_WIDTH_DEF
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic [NUM_OUT-1:0]            cfg_en,
  input  logic [NUM_OUT-1:0]            cfg_sel,
  input  logic [DATA_WIDTH-1:0]         in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [NUM_OUT*DATA_WIDTH-1:0] out_data,
  output logic [NUM_OUT-1:0]            out_valid,
  input  logic [NUM_OUT-1:0]            out_ready,
  output logic [NUM_OUT-1:0]            served
);

  logic [NUM_OUT-1:0]    act, s_q, done, fire;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  head_valid, all_done, retire;

  assign act = NUM_OUT'(active_mask(fanout_mask_t'(cfg_en), fanout_mask_t'(cfg_sel)));

`ifdef FANOUT_SKID_EN
  fanout_skid_buf #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
    .CLK      (CLK),
    .RESET    (RESET),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (head_data),
    .out_valid(head_valid),
    .out_ready(all_done)
  );
`else
  assign head_data  = in_data;
  assign head_valid = in_valid & ~RESET;
  assign in_ready   = all_done & ~RESET;
`endif

  // inactive or already-served branches never hold up retirement
  assign done      = ~act | s_q | out_ready;
  assign all_done  = &done;
  assign retire    = head_valid & all_done;
  assign out_valid = {NUM_OUT{head_valid}} & act & ~s_q;
  assign fire      = out_valid & out_ready;
  assign out_data  = {NUM_OUT{head_data}};
  assign served    = s_q;

  always_ff @(posedge CLK) begin
    if (RESET)       s_q <= '0;
    else if (retire) s_q <= '0;
    else             s_q <= s_q | fire;
  end

endmodule

// File: tb/tb_fanout_fork.sv
// Self-checking bench for fanout_fork: vector table, hand sequences and randomized model check.
module tb_fanout_fork;
  localparam int N = 6;
  localparam int W = 17;

  logic           CLK = 1'b0;
  logic           RESET = 1'b1;
  logic [N-1:0]   cfg_en = '0, cfg_sel = '0, out_ready = '0;
  logic [W-1:0]   in_data = '0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [N*W-1:0] out_data;
  logic [N-1:0]   out_valid, served;

  fanout_fork #(.NUM_OUT(N), .DATA_WIDTH(W)) dut (
    .CLK(CLK), .RESET(RESET), .cfg_en(cfg_en), .cfg_sel(cfg_sel),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .served(served)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;
  int fire_cnt [N];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  always @(negedge CLK) begin
    if (!RESET)
      for (int i = 0; i < N; i++) fire_cnt[i] += int'(out_valid[i] & out_ready[i]);
  end

  typedef struct {
    logic [N-1:0] en, sel, rdy;
    logic         iv;
    logic [W-1:0] d;
    logic [N-1:0] ov;
    logic         ir;
    logic [N-1:0] srv;
  } vec_t;

  vec_t tv[$];

  // randomized-phase reference state
  logic [N-1:0] m_srv, m_act, m_ev, fired, f;
  logic         m_done;

  task automatic rstep();
    logic acc;
    @(negedge CLK);
    m_act  = cfg_en & cfg_sel;
    m_done = 1'b1;
    for (int i = 0; i < N; i++) begin
      m_ev[i] = in_valid & m_act[i] & ~m_srv[i];
      if (m_act[i] && !m_srv[i] && !out_ready[i]) m_done = 1'b0;
    end
    chk("rnd_ov", out_valid, m_ev);
    chk("rnd_ir", in_ready, m_done);
    chk("rnd_srv", served, m_srv);
    f = out_valid & out_ready;
    chk("rnd_dup", f & fired, 0);
    fired |= f;
    acc = in_valid & m_done;
    if (acc) begin
      chk("rnd_once", fired, m_act);
      fired = '0;
      m_srv = '0;
    end else begin
      m_srv |= m_ev & out_ready;
    end
    tick();
    if (acc) in_valid = 1'b0;
  endtask

  initial begin
    int acc_n;
    for (int i = 0; i < N; i++) fire_cnt[i] = 0;
`ifdef FANOUT_SKID_EN
    cfg_en = '1; cfg_sel = 6'b000001; out_ready = '0; in_valid = 1'b1;
    tick(); tick();
    RESET = 1'b0;
    in_data = 17'h00100;
    acc_n = 0;
    for (int c = 0; c < 5; c++) begin
      logic a;
      @(negedge CLK);
      if (c == 0) begin
        chk("skid_ir_first", in_ready, 1'b1);
        chk("skid_ov_c0", out_valid, 6'b000000);
      end
      if (c == 1) chk("skid_ov_c1", out_valid, 6'b000001);
      if (c == 4) chk("skid_ir_full", in_ready, 1'b0);
      a = in_valid & in_ready;
      tick();
      if (a) begin acc_n++; in_data = in_data + 17'd1; end
    end
    chk("skid_acc", acc_n, 2);
    in_valid = 1'b0; out_ready = 6'b000001;
    @(negedge CLK);
    chk("skid_d0_v", out_valid[0], 1'b1);
    chk("skid_d0", out_data[W-1:0], 17'h00100);
    tick();
    @(negedge CLK);
    chk("skid_d1_v", out_valid[0], 1'b1);
    chk("skid_d1", out_data[W-1:0], 17'h00101);
    tick();
    @(negedge CLK);
    chk("skid_empty", out_valid, 6'b000000);
    tick();
`else
    // reset: no readiness or valid while RESET is high
    cfg_en = '1; cfg_sel = '1; out_ready = '1; in_valid = 1'b1; in_data = 17'h1FFFF;
    tick();
    @(negedge CLK);
    chk("rst_ir", in_ready, 1'b0);
    chk("rst_ov", out_valid, 6'b000000);
    chk("rst_srv", served, 6'b000000);
    tick();
    RESET = 1'b0;
    in_valid = 1'b0;

    for (int k = 1; k <= 5; k++)
      tv.push_back('{6'h3F, 6'h3F, 6'h3F, 1'b1, W'(k), 6'h3F, 1'b1, 6'h00});
    tv.push_back('{6'h3F, 6'h07, 6'h01, 1'b1, 17'h0ABCD, 6'h07, 1'b0, 6'h00});
    tv.push_back('{6'h3F, 6'h07, 6'h00, 1'b1, 17'h0ABCD, 6'h06, 1'b0, 6'h01});
    tv.push_back('{6'h3F, 6'h07, 6'h02, 1'b1, 17'h0ABCD, 6'h06, 1'b0, 6'h01});
    tv.push_back('{6'h3F, 6'h07, 6'h00, 1'b1, 17'h0ABCD, 6'h04, 1'b0, 6'h03});
    tv.push_back('{6'h3F, 6'h07, 6'h04, 1'b1, 17'h0ABCD, 6'h04, 1'b1, 6'h03});
    tv.push_back('{6'h3F, 6'h07, 6'h07, 1'b0, 17'h00000, 6'h00, 1'b1, 6'h00});
    tv.push_back('{6'h37, 6'h1F, 6'h17, 1'b1, 17'h01234, 6'h17, 1'b1, 6'h00});
    tv.push_back('{6'h37, 6'h1F, 6'h17, 1'b0, 17'h01234, 6'h00, 1'b1, 6'h00});
    for (int k = 0; k < 4; k++)
      tv.push_back('{6'h00, 6'h00, 6'h00, 1'b1, W'(17'h00200 + k), 6'h00, 1'b1, 6'h00});
    // branch 1 deselected while its token is pending
    tv.push_back('{6'h3F, 6'h03, 6'h01, 1'b1, 17'h00055, 6'h03, 1'b0, 6'h00});
    tv.push_back('{6'h3F, 6'h01, 6'h00, 1'b1, 17'h00055, 6'h00, 1'b1, 6'h01});
    tv.push_back('{6'h3F, 6'h01, 6'h00, 1'b0, 17'h00000, 6'h00, 1'b0, 6'h00});

    for (int k = 0; k < tv.size(); k++) begin
      cfg_en = tv[k].en; cfg_sel = tv[k].sel; out_ready = tv[k].rdy;
      in_valid = tv[k].iv; in_data = tv[k].d;
      @(negedge CLK);
      chk($sformatf("vec%0d_ov", k), out_valid, tv[k].ov);
      chk($sformatf("vec%0d_ir", k), in_ready, tv[k].ir);
      chk($sformatf("vec%0d_srv", k), served, tv[k].srv);
      chk($sformatf("vec%0d_data", k), out_data, {N{in_data}});
      tick();
    end
    chk("fires_b0", fire_cnt[0], 8);
    chk("fires_b1", fire_cnt[1], 7);
    chk("fires_b2", fire_cnt[2], 7);
    chk("fires_b3", fire_cnt[3], 5);
    chk("fires_b4", fire_cnt[4], 6);
    chk("fires_b5", fire_cnt[5], 5);

    // reset while branch 0 has served and branch 1 is stalled
    cfg_en = '1; cfg_sel = 6'b000011; in_valid = 1'b1; in_data = 17'h00099; out_ready = 6'b000001;
    tick();
    out_ready = 6'b000000;
    @(negedge CLK);
    chk("mid_srv", served, 6'b000001);
    chk("mid_ov", out_valid, 6'b000010);
    tick();
    RESET = 1'b1;
    @(negedge CLK);
    chk("mid_rst_ir", in_ready, 1'b0);
    chk("mid_rst_ov", out_valid, 6'b000000);
    tick();
    RESET = 1'b0;
    in_data = 17'h00042; out_ready = 6'b000011;
    @(negedge CLK);
    chk("post_srv", served, 6'b000000);
    chk("post_ov", out_valid, 6'b000011);
    chk("post_data", out_data[2*W-1:0], {2{17'h00042}});
    chk("post_ir", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    @(negedge CLK);
    chk("post_no_replay", out_valid, 6'b000000);
    tick();

    // randomized traffic against the reference model
    m_srv = '0; fired = '0;
    for (int c = 0; c < 5; c++) begin
      cfg_en  = N'($urandom);
      cfg_sel = (c == 4) ? '0 : N'($urandom);
      for (int t = 0; t < 80; t++) begin
        if (!in_valid) begin
          in_valid = ($urandom_range(0, 3) != 0);
          in_data  = W'($urandom);
        end
        out_ready = N'($urandom) | N'($urandom);
        rstep();
      end
      out_ready = '1;
      for (int t = 0; t < 2 && in_valid; t++) rstep();
      chk("rnd_drained", in_valid, 1'b0);
    end
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
